// File: rtl/config_chain_loader.sv
// CCFF chain programming front end: takes host words over valid/ready and
// shifts them LSB-first into the configuration chain, one bit per prog_clk.
module config_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_data,
    output logic              load_ready,
    output logic              ccff_head,
    output logic              chain_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              tail_parity
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int REM_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [REM_W-1:0] WORD_REM = REM_W'(WORD_W - 1);

    state_t            state;
    logic [WORD_W-1:0] sr;       // bits of the current word not yet presented
    logic [REM_W-1:0]  rem;      // how many of those remain
    logic [CNT_W-1:0]  bit_cnt;  // index of the bit on ccff_head when chain_en=1

    logic              accept;
    logic              is_final;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              en_nxt;
    logic              head_nxt;
    logic [WORD_W-1:0] sr_nxt;
    logic [REM_W-1:0]  rem_nxt;
    logic              ready_nxt;

    // NOTE: every signal gets a default at the top of always_comb, so no path
    // can leave one unassigned and infer a latch.
    always_comb begin
        accept    = load_valid && load_ready;
        is_final  = chain_en && (bit_cnt == LAST_BIT);
        cnt_nxt   = bit_cnt + CNT_W'(chain_en);
        en_nxt    = 1'b0;
        head_nxt  = ccff_head;
        sr_nxt    = sr;
        rem_nxt   = '0;
        ready_nxt = 1'b0;

        if (rem != '0) begin
            en_nxt   = 1'b1;
            head_nxt = sr[0];
            sr_nxt   = sr >> 1;
            rem_nxt  = rem - REM_W'(1);
        end else if (accept) begin
            en_nxt   = 1'b1;
            head_nxt = load_data[0];
            sr_nxt   = load_data >> 1;
            rem_nxt  = WORD_REM;
        end

        // A new word would start at cnt_nxt (+1 if a bit is presented next
        // cycle); it must still land inside the chain.
        if (rem_nxt == '0) begin
            ready_nxt = en_nxt ? (cnt_nxt < LAST_BIT) : 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
            state       <= IDLE;
            sr          <= '0;
            rem         <= '0;
            bit_cnt     <= '0;
            load_ready  <= 1'b0;
            ccff_head   <= 1'b0;
            chain_en    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            tail_parity <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= SHIFT;
                        sr          <= '0;
                        rem         <= '0;
                        bit_cnt     <= '0;
                        tail_parity <= 1'b0;
                        overflow    <= 1'b0;
                        load_ready  <= 1'b1;
                        chain_en    <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end else if (state == DONE && load_valid) begin
                        overflow <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (chain_en) begin
                        tail_parity <= tail_parity ^ ccff_tail;
                    end
                    bit_cnt <= cnt_nxt;

                    if (is_final) begin
                        // Leftover bits of a partial final word are dropped.
                        state      <= DONE;
                        rem        <= '0;
                        chain_en   <= 1'b0;
                        load_ready <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        chain_en   <= en_nxt;
                        ccff_head  <= head_nxt;
                        sr         <= sr_nxt;
                        rem        <= rem_nxt;
                        load_ready <= ready_nxt;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader with a 40-bit chain and 32-bit words;
// a behavioural chain model loops ccff_head back to ccff_tail.
module tb_config_chain_loader;

    localparam int WORD_W    = 32;
    localparam int CHAIN_LEN = 40;
    localparam int CNT_W     = 16;

    logic              prog_clk;
    logic              pReset_n;
    logic              start;
    logic              load_valid;
    logic [WORD_W-1:0] load_data;
    logic              load_ready;
    logic              ccff_head;
    logic              chain_en;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic              overflow;
    logic              tail_parity;

    logic [CHAIN_LEN-1:0] chain_q;
    logic [CHAIN_LEN-1:0] preload_val;
    logic                 preload_req;

    int n_tests;
    int n_fail;

    config_chain_loader #(
        .WORD_W   (WORD_W),
        .CHAIN_LEN(CHAIN_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .prog_clk   (prog_clk),
        .pReset_n   (pReset_n),
        .start      (start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .ccff_head  (ccff_head),
        .chain_en   (chain_en),
        .ccff_tail  (ccff_tail),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .tail_parity(tail_parity)
    );

    initial begin
        prog_clk = 1'b0;
        forever #5 prog_clk = ~prog_clk;
    end

    // Chain model: head enters at the top, tail leaves from bit 0.
    always @(posedge prog_clk) begin
        if (preload_req) chain_q <= preload_val;
        else if (chain_en) chain_q <= {ccff_head, chain_q[CHAIN_LEN-1:1]};
    end
    assign ccff_tail = chain_q[0];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {load_ready, ccff_head, chain_en, busy, done, overflow, tail_parity};
    endfunction

    task automatic preload_chain(input logic [CHAIN_LEN-1:0] v);
        @(negedge prog_clk);
        preload_val = v;
        preload_req = 1'b1;
        @(negedge prog_clk);
        preload_req = 1'b0;
    endtask

    // Runs one two-word load; inputs are driven and outputs sampled on negedges.
    // lat = cycles from first acceptance edge until done is seen.
    task automatic do_load(input logic [31:0] w0, input logic [31:0] w1, input int stall,
                           output int lat, output int rdy_hi, output int ce_n,
                           output int stall_n, output int frz_bad,
                           output logic [CHAIN_LEN-1:0] strm);
        int   widx;
        int   t;
        int   gap;
        int   n;
        logic hd;
        widx = 0; t = -1; gap = stall; n = 0; hd = 1'b0;
        lat = -1; rdy_hi = 0; ce_n = 0; stall_n = 0; frz_bad = 0; strm = '0;

        @(negedge prog_clk);
        start      = 1'b1;
        load_valid = 1'b0;
        @(negedge prog_clk);
        start = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_done", done, 1'b0);
        check("start_ovf_clr", overflow, 1'b0);
        check("start_ready", load_ready, 1'b1);

        for (int cyc = 0; cyc < 200; cyc++) begin
            if (t >= 0) t++;
            if (done) begin
                lat = t;
                break;
            end
            if (chain_en) begin
                if (n < CHAIN_LEN) strm[n] = ccff_head;
                n++;
                ce_n++;
                hd = ccff_head;
            end else if (t >= 1) begin
                stall_n++;
                if (ccff_head !== hd) frz_bad++;
            end
            if (load_ready) rdy_hi++;
            start = (t == 10);
            if (widx < 2) begin
                if (widx == 1 && load_ready && gap > 0) begin
                    load_valid = 1'b0;
                    gap--;
                end else begin
                    load_valid = 1'b1;
                    load_data  = (widx == 0) ? w0 : w1;
                end
            end else begin
                load_valid = 1'b0;
            end
            if (load_valid && load_ready) begin
                widx++;
                if (t < 0) t = 0;
            end
            @(negedge prog_clk);
        end
        start      = 1'b0;
        load_valid = 1'b0;
    endtask

    int                   lat, rdy_hi, ce_n, stall_n, frz_bad, n;
    logic                 hit;
    logic [CHAIN_LEN-1:0] strm;

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        pReset_n    = 1'b0;
        start       = 1'b0;
        load_valid  = 1'b0;
        load_data   = '0;
        preload_req = 1'b0;
        preload_val = '0;

        repeat (3) @(negedge prog_clk);
        check("reset_outs", outs(), 7'b0);
        pReset_n = 1'b1;
        @(negedge prog_clk);
        check("idle_outs", outs(), 7'b0);

        // Basic two-word load into an all-zero chain.
        preload_chain('0);
        do_load(32'hA5A5_A5A5, 32'h0000_00FF, 0, lat, rdy_hi, ce_n, stall_n, frz_bad, strm);
        check("basic_latency", lat, 41);
        check("basic_ready_cnt", rdy_hi, 2);
        check("basic_chain_en_cnt", ce_n, 40);
        check("basic_no_stall", stall_n, 0);
        check("basic_stream", strm, {8'hFF, 32'hA5A5_A5A5});
        check("basic_chain_model", chain_q, {8'hFF, 32'hA5A5_A5A5});
        check("basic_parity", tail_parity, 1'b0);
        check("basic_done_outs", {load_ready, chain_en, busy, done}, 4'b0001);

        // Overflow: a word offered after done.
        load_valid = 1'b1;
        load_data  = 32'h1234_5678;
        @(negedge prog_clk);
        check("ovf_set", overflow, 1'b1);
        check("ovf_ready", load_ready, 1'b0);
        check("ovf_chain_en", chain_en, 1'b0);
        load_valid = 1'b0;
        repeat (3) @(negedge prog_clk);
        check("ovf_sticky", overflow, 1'b1);
        check("ovf_chain_untouched", chain_q, {8'hFF, 32'hA5A5_A5A5});

        // Reconfiguration from DONE with a stall and three ones in the chain.
        preload_chain(40'h80_0001_0001);
        check("ovf_before_reconf", overflow, 1'b1);
        do_load(32'hDEAD_BEEF, 32'h0000_0055, 5, lat, rdy_hi, ce_n, stall_n, frz_bad, strm);
        check("stall_latency", lat, 46);
        check("stall_cycles", stall_n, 5);
        check("stall_head_held", frz_bad, 0);
        check("stall_ready_cnt", rdy_hi, 7);
        check("stall_chain_en_cnt", ce_n, 40);
        check("stall_stream", strm, {8'h55, 32'hDEAD_BEEF});
        check("parity_three_ones", tail_parity, 1'b1);
        check("reconf_done", done, 1'b1);

        // Reset in the middle of a load at bit 17.
        @(negedge prog_clk);
        start = 1'b1;
        @(negedge prog_clk);
        start      = 1'b0;
        load_valid = 1'b1;
        load_data  = 32'hFFFF_FFFF;
        n   = 0;
        hit = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (chain_en) begin
                if (n == 17) begin
                    hit = 1'b1;
                    break;
                end
                n++;
            end
            @(negedge prog_clk);
        end
        check("midrst_reach_bit17", hit, 1'b1);
        pReset_n   = 1'b0;
        load_valid = 1'b0;
        @(negedge prog_clk);
        check("midrst_outs", outs(), 7'b0);
        pReset_n = 1'b1;
        @(negedge prog_clk);
        check("midrst_idle", outs(), 7'b0);

        do_load(32'h1234_0F0F, 32'h0000_00C3, 0, lat, rdy_hi, ce_n, stall_n, frz_bad, strm);
        check("reload_latency", lat, 41);
        check("reload_stream", strm, {8'hC3, 32'h1234_0F0F});
        check("reload_chain_model", chain_q, {8'hC3, 32'h1234_0F0F});
        check("reload_ready_cnt", rdy_hi, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Programming-side front end for the configuration-flip-flop (CCFF) chain.
- Accepts bitstream words from the host interface through a valid/ready handshake and serializes them LSB-first onto ccff_head, one bit per prog_clk cycle.
- Counts exactly CHAIN_LEN bits, then asserts done. The fabric uses done to release the configured transmission-gate selects and the routing buffers into user mode.

Parameters:
- WORD_W, 32: width of a host bitstream word.
- CHAIN_LEN, 1024: total number of CCFF bits in the chain.
- CNT_W, 16: width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- prog_clk  in  1  programming clock; all logic is on the rising edge.
- pReset_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse that begins a load; ignored unless the state is IDLE or DONE.
- load_valid  in  1  host word valid.
- load_data  in  WORD_W  host word; bit 0 is shifted first.
- load_ready  out  1  loader accepts load_data in this cycle.
- ccff_head  out  1  serial data into the chain.
- chain_en  out  1  chain shift enable; the CCFFs capture ccff_head when this is high.
- ccff_tail  in  1  serial data out of the chain end.
- busy  out  1  high in state SHIFT.
- done  out  1  high in state DONE; configuration is valid.
- overflow  out  1  sticky: the host offered a word after the final bit.
- tail_parity  out  1  XOR of every ccff_tail bit sampled during shifting.

Behaviour:
- One clock (prog_clk); reset is synchronous, active-low (pReset_n).
- Reset: state IDLE. load_ready=0, ccff_head=0, chain_en=0, busy=0, done=0, overflow=0, tail_parity=0. The bit counter and shift register are cleared.
- Reset mid-load aborts immediately. The chain contents are then undefined and done stays 0.
- State IDLE:
  - All outputs are 0.
  - start moves to SHIFT on the next edge, clearing the counter, tail_parity and overflow.
- State DONE:
  - done=1; all other outputs hold their last values.
  - start re-enters SHIFT with the same clearing as from IDLE, which gives reconfiguration.
- State SHIFT, handshake:
  - load_ready=1 when the shift register holds 0 bits, or holds exactly 1 bit being presented this cycle with more chain bits remaining. This gives back-to-back streaming with no bubble.
  - A word is accepted when load_valid && load_ready.
- State SHIFT, latency:
  - A word accepted at edge T presents bit 0 on ccff_head with chain_en=1 in cycle T+1.
  - Bit k is presented in cycle T+1+k.
- State SHIFT, shifting:
  - Each cycle with chain_en=1 increments the bit counter and XORs ccff_tail into tail_parity.
  - Stall (shift register empty, no valid word): chain_en=0, ccff_head holds its last value, and the counter does not advance.
- State SHIFT, final word:
  - When the counter reaches CHAIN_LEN-1 with chain_en=1, that is the final bit. The next state is DONE.
  - The remaining bits of a partial final word are discarded; chain_en drops to 0 the following cycle.
  - load_ready is never asserted for a word that would begin at bit CHAIN_LEN.
- Overflow: load_valid=1 while in DONE sets overflow=1. The word is not accepted and the chain is untouched.
- start asserted while in SHIFT is ignored.
- Words needed per load = ceil(CHAIN_LEN/WORD_W).
- Minimum load time = CHAIN_LEN + 1 cycles after the first acceptance.

Test Plan:
- Parameters CHAIN_LEN=40, WORD_W=32:
  - Stimulus: start, then words 0xA5A5A5A5 and 0x000000FF with load_valid held high.
  - Response: ccff_head shows 0xA5A5A5A5 LSB-first, then 0xFF's low 8 bits, over 40 contiguous chain_en cycles. done=1 at cycle 41 after first acceptance; load_ready was high exactly twice.
- Stall:
  - Stimulus: drop load_valid for 5 cycles between words.
  - Response: chain_en=0 and ccff_head held for those 5 cycles; the counter is frozen; done is delayed by exactly 5 cycles.
- Overflow:
  - Stimulus: after done, drive load_valid=1 with 0x12345678.
  - Response: overflow=1 and stays set; load_ready=0; chain_en stays 0.
- Tail parity:
  - Stimulus: loop ccff_tail through a 40-bit model chain preloaded with 3 ones.
  - Response: tail_parity=1 at done.
- Reset mid-shift:
  - Stimulus: pReset_n=0 for 1 cycle at bit 17.
  - Response: all outputs 0 on the next edge; a new start then reloads from bit 0.
- Reconfiguration:
  - Stimulus: start while in DONE with overflow=1.
  - Response: overflow cleared, busy=1, done=0; a full 40-bit reload completes.
